// File: rtl/dmem_responder.sv
// Memory-side responder for the core's load/store port: valid/ready request and response channels,
// programmable latency, RV32I sizing and extension.
module dmem_responder #(
  parameter int ADDR_WIDTH = 17,
  parameter int D_WIDTH    = 32,
  parameter int LATENCY    = 2,
  parameter     INIT_FILE  = "data.hex"
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [31:0]        req_addr,
  input  logic [D_WIDTH-1:0] req_wdata,
  input  logic [2:0]         req_funct3,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [D_WIDTH-1:0] resp_rdata,
  output logic               resp_err
);

  localparam int         WORDS    = 2 ** (ADDR_WIDTH - 2);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  funct3_q;

  logic        accept, commit, err, write_en;
  logic [3:0]  be;
  logic [31:0] wlanes;
  logic [31:0] rd_word;
  logic [31:0] rdata_ext;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [ADDR_WIDTH-3:0] idx;

  logic [31:0] mem [0:WORDS-1] = '{default: '0};

  assign accept     = req_valid && req_ready;
  assign commit     = (state == WAIT) && (cnt == 4'd0);
  assign req_ready  = (state == IDLE) && !rst;
  assign resp_valid = (state == RESP);
  assign idx        = addr_q[ADDR_WIDTH-1:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        we_q     <= req_we;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        funct3_q <= req_funct3;
      end
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: if (accept) begin
        state_next = WAIT;
        cnt_next   = CNT_INIT;
      end
      WAIT: if (cnt == 4'd0) state_next = RESP;
            else             cnt_next   = cnt - 4'd1;
      RESP: if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    err = 1'b0;
    case (funct3_q)
      3'b000:  err = 1'b0;
      3'b001:  err = addr_q[0];
      3'b010:  err = |addr_q[1:0];
      3'b100:  err = we_q;
      3'b101:  err = we_q | addr_q[0];
      default: err = 1'b1;
    endcase
    if (|addr_q[31:ADDR_WIDTH]) err = 1'b1;
  end

  // Store data is replicated across lanes so the byte enables alone select what lands.
  always_comb begin
    be     = 4'b0000;
    wlanes = wdata_q;
    case (funct3_q[1:0])
      2'b00: begin
        be     = 4'b0001 << addr_q[1:0];
        wlanes = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be     = addr_q[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{wdata_q[15:0]}};
      end
      default: be = 4'b1111;
    endcase
  end

  assign write_en = commit && we_q && !err;

  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (write_en && be[k]) mem[idx][8*k +: 8] <= wlanes[8*k +: 8];
    if (commit) rd_word <= mem[idx];
  end

  assign byte_sel = rd_word[{addr_q[1:0], 3'b000} +: 8];
  assign half_sel = rd_word[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    rdata_ext = '0;
    case (funct3_q)
      3'b000:  rdata_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  rdata_ext = {{16{half_sel[15]}}, half_sel};
      3'b010:  rdata_ext = rd_word;
      3'b100:  rdata_ext = {24'd0, byte_sel};
      3'b101:  rdata_ext = {16'd0, half_sel};
      default: rdata_ext = '0;
    endcase
  end

  assign resp_rdata = (state == RESP && !we_q && !err) ? rdata_ext : '0;
  assign resp_err   = (state == RESP) && err;

endmodule
